// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target register interface.
// Contents: transfer FSM state enum, ACK/NACK bus levels, bit-counter width.
package i2c_target_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StPtr,
        StPtrAck,
        StWdata,
        StWdataAck,
        StRdata,
        StRdataAck,
        StIgnore
    } i2c_state_e;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam int unsigned BitCntW = 4;

endpackage

// File: rtl/i2c_pad_filter.sv
// Conditions one raw I2C pad line: 2-FF synchronizer, stability filter and edge detector.
// Ports:
//   clk_i   - system clock
//   rst_i   - synchronous active-high reset (line idles high)
//   pad_i   - raw, asynchronous pad level
//   level_o - filtered level
//   rise_o  - one-cycle pulse when the filtered level goes 0 -> 1
//   fall_o  - one-cycle pulse when the filtered level goes 1 -> 0
module i2c_pad_filter #(
    parameter int unsigned FiltLen = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pad_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CntW = (FiltLen > 1) ? $clog2(FiltLen) : 1;

    logic [1:0]      sync_q;
    logic [CntW-1:0] cnt_q;
    logic            level_q;
    logic            rise_q;
    logic            fall_q;
    logic            accept;

    // cnt_q counts consecutive synchronized samples that differ from the filtered level;
    // the FiltLen-th such sample is accepted as the new level.
    assign accept = (sync_q[1] != level_q) && (cnt_q == CntW'(FiltLen - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], pad_i};
            rise_q <= accept & sync_q[1];
            fall_q <= accept & ~sync_q[1];
            if ((sync_q[1] == level_q) || accept) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CntW'(1);
            end
            if (accept) begin
                level_q <= sync_q[1];
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_target_regif.sv
// I2C target responder exposing an 8-bit-addressed byte register space.
// Decodes START/STOP, device address, register pointer and data bytes from the pads and
// drives ACK / read data back through an open-drain SDA output.
// Ports:
//   clk_clk, rst_reset          - clock, synchronous active-high reset
//   scl_pad_i, sda_pad_i        - raw pad levels
//   sda_pad_o, sda_padoen_o     - SDA output (always 0) and active-low output enable
//   wr_valid, wr_addr, wr_data  - one-cycle register write strobe with address/data
//   rd_req, rd_addr, rd_data    - one-cycle read fetch strobe; rd_data valid the next cycle
//   busy                        - high from an addressed START until STOP
module i2c_target_regif
    import i2c_target_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR = 7'h3C,
    parameter int unsigned FILT_LEN = 4,
    parameter int unsigned HOLD_CYC = 8    // must be >= 1
) (
    input  logic       clk_clk,
    input  logic       rst_reset,
    input  logic       scl_pad_i,
    input  logic       sda_pad_i,
    output logic       sda_pad_o,
    output logic       sda_padoen_o,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [7:0] rd_addr,
    output logic       rd_req,
    input  logic [7:0] rd_data,
    output logic       busy
);

    localparam int unsigned HoldW = $clog2(HOLD_CYC + 1);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_det, stop_det;

    i2c_pad_filter #(.FiltLen(FILT_LEN)) u_scl_filter (
        .clk_i   (clk_clk),
        .rst_i   (rst_reset),
        .pad_i   (scl_pad_i),
        .level_o (scl_lvl),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    i2c_pad_filter #(.FiltLen(FILT_LEN)) u_sda_filter (
        .clk_i   (clk_clk),
        .rst_i   (rst_reset),
        .pad_i   (sda_pad_i),
        .level_o (sda_lvl),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    i2c_state_e         state_q;
    logic [BitCntW-1:0] bit_cnt_q;
    logic [7:0]         shift_q;
    logic [7:0]         ptr_q;
    logic               rw_q;
    logic               busy_q;
    logic               oe_n_q;    // registered SDA enable, 1 = released
    logic               pend_q;    // value oe_n_q takes when the hold timer expires
    logic [HoldW-1:0]   hold_q;
    logic               wr_valid_q;
    logic [7:0]         wr_addr_q;
    logic [7:0]         wr_data_q;
    logic               rd_req_q;
    logic [7:0]         rd_addr_q;
    logic               fetch_q;   // rd_data is valid this cycle
    logic [7:0]         rx_byte;

    assign rx_byte = {shift_q[6:0], sda_lvl};

    always_ff @(posedge clk_clk) begin
        if (rst_reset) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            ptr_q      <= '0;
            rw_q       <= 1'b0;
            busy_q     <= 1'b0;
            oe_n_q     <= 1'b1;
            pend_q     <= 1'b1;
            hold_q     <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_req_q   <= 1'b0;
            rd_addr_q  <= '0;
            fetch_q    <= 1'b0;
        end else begin
            wr_valid_q <= 1'b0;
            rd_req_q   <= 1'b0;
            fetch_q    <= rd_req_q;
            if (fetch_q) begin
                shift_q <= rd_data;
            end
            if (hold_q != '0) begin
                hold_q <= hold_q - HoldW'(1);
                if (hold_q == HoldW'(1)) begin
                    oe_n_q <= pend_q;
                end
            end

            if (start_det) begin
                // Repeated START wins over anything in flight, including an ACK being driven.
                state_q   <= StAddr;
                bit_cnt_q <= '0;
                oe_n_q    <= 1'b1;
                hold_q    <= '0;
            end else if (stop_det) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
                oe_n_q  <= 1'b1;
                hold_q  <= '0;
            end else begin
                case (state_q)
                    StAddr, StPtr, StWdata: begin
                        if (scl_fall) begin
                            pend_q <= NACK;
                            hold_q <= HoldW'(HOLD_CYC);
                        end
                        if (scl_rise) begin
                            shift_q   <= rx_byte;
                            bit_cnt_q <= bit_cnt_q + BitCntW'(1);
                            if (bit_cnt_q == BitCntW'(7)) begin
                                bit_cnt_q <= '0;
                                case (state_q)
                                    StAddr: begin
                                        if (rx_byte[7:1] == DEV_ADDR) begin
                                            busy_q  <= 1'b1;
                                            rw_q    <= rx_byte[0];
                                            state_q <= StAddrAck;
                                        end else begin
                                            state_q <= StIgnore;
                                        end
                                    end
                                    StPtr: begin
                                        ptr_q   <= rx_byte;
                                        state_q <= StPtrAck;
                                    end
                                    default: begin
                                        wr_valid_q <= 1'b1;
                                        wr_addr_q  <= ptr_q;
                                        wr_data_q  <= rx_byte;
                                        ptr_q      <= ptr_q + 8'd1;
                                        state_q    <= StWdataAck;
                                    end
                                endcase
                            end
                        end
                    end
                    // Entered at the 8th rise: ACK goes out after the 8th fall, and the next
                    // state starts at the 9th rise so a read fetch completes before the 9th fall.
                    StAddrAck, StPtrAck, StWdataAck: begin
                        if (scl_fall) begin
                            pend_q <= ACK;
                            hold_q <= HoldW'(HOLD_CYC);
                        end
                        if (scl_rise) begin
                            bit_cnt_q <= '0;
                            if ((state_q == StAddrAck) && rw_q) begin
                                state_q   <= StRdata;
                                rd_req_q  <= 1'b1;
                                rd_addr_q <= ptr_q;
                            end else if (state_q == StAddrAck) begin
                                state_q <= StPtr;
                            end else begin
                                state_q <= StWdata;
                            end
                        end
                    end
                    StRdata: begin
                        if (scl_fall) begin
                            hold_q <= HoldW'(HOLD_CYC);
                            if (bit_cnt_q == BitCntW'(8)) begin
                                pend_q  <= NACK;
                                state_q <= StRdataAck;
                            end else begin
                                pend_q    <= shift_q[7];
                                shift_q   <= {shift_q[6:0], 1'b0};
                                bit_cnt_q <= bit_cnt_q + BitCntW'(1);
                            end
                        end
                    end
                    StRdataAck: begin
                        if (scl_rise) begin
                            if (sda_lvl == ACK) begin
                                ptr_q     <= ptr_q + 8'd1;
                                rd_req_q  <= 1'b1;
                                rd_addr_q <= ptr_q + 8'd1;
                                bit_cnt_q <= '0;
                                state_q   <= StRdata;
                            end else begin
                                state_q <= StIgnore;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sda_pad_o    = 1'b0;
    assign sda_padoen_o = oe_n_q;
    assign wr_valid     = wr_valid_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign rd_req       = rd_req_q;
    assign rd_addr      = rd_addr_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_i2c_target_regif.sv
// Directed bench for i2c_target_regif: bit-banged I2C master on the pads, wired-AND SDA,
// register port responder returning addr ^ 0xFF, and logs of write / fetch strobes.
module tb_i2c_target_regif;

    localparam int unsigned Q = 20;  // clk cycles per quarter SCL period

    logic       clk_clk = 1'b0;
    logic       rst_reset;
    logic       scl_m;
    logic       sda_m;
    logic       sda_bus;
    logic       sda_pad_o;
    logic       sda_padoen_o;
    logic       wr_valid;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] rd_addr;
    logic       rd_req;
    logic [7:0] rd_data = 8'h00;
    logic       busy;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    logic [15:0] wr_log[$];
    logic [7:0]  rd_log[$];

    always #5 clk_clk = ~clk_clk;

    assign sda_bus = sda_m & (sda_padoen_o | sda_pad_o);

    i2c_target_regif dut (
        .clk_clk      (clk_clk),
        .rst_reset    (rst_reset),
        .scl_pad_i    (scl_m),
        .sda_pad_i    (sda_bus),
        .sda_pad_o    (sda_pad_o),
        .sda_padoen_o (sda_padoen_o),
        .wr_valid     (wr_valid),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_addr      (rd_addr),
        .rd_req       (rd_req),
        .rd_data      (rd_data),
        .busy         (busy)
    );

    always @(negedge clk_clk) begin
        if (wr_valid) wr_log.push_back({wr_addr, wr_data});
        if (rd_req) begin
            rd_log.push_back(rd_addr);
            rd_data = rd_addr ^ 8'hFF;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    endtask

    task automatic check_wr(input string tag, input logic [15:0] exp_v);
        logic [31:0] obs;
        obs = 32'hFFFF_FFFF;
        if (wr_log.size() > 0) obs = {16'h0, wr_log.pop_front()};
        check(tag, obs, {16'h0, exp_v});
    endtask

    task automatic check_rd(input string tag, input logic [7:0] exp_v);
        logic [31:0] obs;
        obs = 32'hFFFF_FFFF;
        if (rd_log.size() > 0) obs = {24'h0, rd_log.pop_front()};
        check(tag, obs, {24'h0, exp_v});
    endtask

    task automatic wait_q(input int unsigned n);
        repeat (n) @(negedge clk_clk);
    endtask

    task automatic i2c_start;
        sda_m = 1'b1; wait_q(Q);
        scl_m = 1'b1; wait_q(Q);
        sda_m = 1'b0; wait_q(Q);
        scl_m = 1'b0; wait_q(Q);
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0; wait_q(Q);
        scl_m = 1'b1; wait_q(Q);
        sda_m = 1'b1; wait_q(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; wait_q(Q);
            scl_m = 1'b1; wait_q(2 * Q);
            scl_m = 1'b0; wait_q(Q);
        end
        sda_m = 1'b1; wait_q(Q);
        scl_m = 1'b1; wait_q(Q);
        ack = sda_bus; wait_q(Q);
        scl_m = 1'b0; wait_q(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; wait_q(Q);
        scl_m = 1'b1; wait_q(Q);
        b = sda_bus; wait_q(Q);
        scl_m = 1'b0; wait_q(Q);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] b);
        logic bit_v;
        for (int i = 7; i >= 0; i--) begin
            read_bit(bit_v);
            b[i] = bit_v;
        end
        sda_m = mack; wait_q(Q);
        scl_m = 1'b1; wait_q(2 * Q);
        scl_m = 1'b0; wait_q(Q);
    endtask

    initial begin
        logic       ack;
        logic [7:0] rb;

        rst_reset = 1'b1;
        scl_m     = 1'b1;
        sda_m     = 1'b1;
        wait_q(5);
        check("rst_padoen", sda_padoen_o, 1);
        check("rst_pad_o", sda_pad_o, 0);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_rd_req", rd_req, 0);
        check("rst_busy", busy, 0);
        check("rst_addrs", {wr_addr, wr_data, rd_addr}, 0);
        rst_reset = 1'b0;
        wait_q(2 * Q);

        // Write two bytes from pointer 0x10
        i2c_start;
        write_byte(8'h78, ack); check("t1_addr_ack", ack, 0);
        check("t1_busy_on", busy, 1);
        write_byte(8'h10, ack); check("t1_ptr_ack", ack, 0);
        write_byte(8'hA5, ack); check("t1_d0_ack", ack, 0);
        write_byte(8'h5A, ack); check("t1_d1_ack", ack, 0);
        i2c_stop;
        check("t1_busy_off", busy, 0);
        check_wr("t1_wr0", 16'h10A5);
        check_wr("t1_wr1", 16'h115A);
        check("t1_wr_extra", wr_log.size(), 0);

        // Pointer write, repeated START, read two bytes
        i2c_start;
        write_byte(8'h78, ack); check("t2_addr_ack", ack, 0);
        write_byte(8'h20, ack); check("t2_ptr_ack", ack, 0);
        i2c_start;
        write_byte(8'h79, ack); check("t2_raddr_ack", ack, 0);
        read_byte(1'b0, rb); check("t2_rd0", rb, 8'hDF);
        read_byte(1'b1, rb); check("t2_rd1", rb, 8'hDE);
        i2c_stop;
        check("t2_busy_off", busy, 0);
        check_rd("t2_fetch0", 8'h20);
        check_rd("t2_fetch1", 8'h21);
        check("t2_fetch_extra", rd_log.size(), 0);
        check("t2_no_wr", wr_log.size(), 0);

        // Foreign address is ignored
        i2c_start;
        write_byte(8'h50, ack); check("t3_nack", ack, 1);
        check("t3_busy", busy, 0);
        i2c_stop;
        check("t3_no_wr", wr_log.size(), 0);
        check("t3_no_rd", rd_log.size(), 0);

        // Pointer wraps 0xFF -> 0x00
        i2c_start;
        write_byte(8'h78, ack); check("t4_addr_ack", ack, 0);
        write_byte(8'hFF, ack);
        write_byte(8'h01, ack);
        write_byte(8'h02, ack);
        write_byte(8'h03, ack); check("t4_d2_ack", ack, 0);
        i2c_stop;
        check_wr("t4_wr0", 16'hFF01);
        check_wr("t4_wr1", 16'h0002);
        check_wr("t4_wr2", 16'h0103);

        // 2-cycle SDA glitch with SCL high must not look like a START
        sda_m = 1'b0; wait_q(2);
        sda_m = 1'b1; wait_q(Q);
        scl_m = 1'b0; wait_q(Q);
        write_byte(8'h78, ack); check("t5_glitch_nack", ack, 1);
        check("t5_busy", busy, 0);
        i2c_stop;
        check("t5_no_wr", wr_log.size(), 0);

        // Reset while the target drives a 0 data bit
        i2c_start;
        write_byte(8'h78, ack);
        write_byte(8'h20, ack);
        i2c_start;
        write_byte(8'h79, ack); check("t6_raddr_ack", ack, 0);
        read_bit(ack); check("t6_bit7", ack, 1);
        read_bit(ack); check("t6_bit6", ack, 1);
        wait_q(Q / 2);
        check("t6_driving0", sda_padoen_o, 0);
        rst_reset = 1'b1; wait_q(1);
        rst_reset = 1'b0;
        check("t6_released", sda_padoen_o, 1);
        check("t6_busy", busy, 0);
        rd_log.delete();
        wait_q(Q);
        scl_m = 1'b1; wait_q(2 * Q);
        i2c_start;
        write_byte(8'h78, ack); check("t6_addr_ack", ack, 0);
        write_byte(8'h30, ack);
        write_byte(8'h3C, ack); check("t6_d_ack", ack, 0);
        i2c_stop;
        check_wr("t6_wr", 16'h303C);
        check("t6_no_rd", rd_log.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
